// File: rtl/systemizer_pkg.sv
// rtl/systemizer_pkg.sv - shared FSM state and systemizer status encodings
// Contents: state_t (controller FSM states), sys_status_t (systemizer
// completion flags as one code), sys_status() to build that code.
package systemizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // {fail, success} as reported with sys_done; only SUCCESS is a good attempt
  typedef enum logic [1:0] {
    SYS_ST_NONE    = 2'b00,
    SYS_ST_SUCCESS = 2'b01,
    SYS_ST_FAIL    = 2'b10,
    SYS_ST_BOTH    = 2'b11
  } sys_status_t;

  localparam logic [2:0] TRY_CNT_MAX = 3'd7;

  function automatic sys_status_t sys_status(input logic success, input logic fail);
    return sys_status_t'({fail, success});
  endfunction

endpackage

// File: rtl/sysctl_unload_buf.sv
// rtl/sysctl_unload_buf.sv - 1-cycle-latency RAM reader to valid/ready stream
// Ports: clk, rst_n (async active-low); en (clears everything when low);
// rd_addr / rd_data (RAM address, data one cycle later);
// out_valid / out_data / out_ready (stream); out_last (current word is DEPTH-1).
module sysctl_unload_buf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [ADDR_W:0]   rd_ptr;
  logic              inflight;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] acc_cnt;

  logic       pop;
  logic       load_out;
  logic [1:0] occ;
  logic       issue;

  // A read is issued only when the word it returns is guaranteed a slot
  // (output or skid register) even if the consumer stalls from now on.
  always_comb begin
    pop      = out_valid_q && out_ready;
    load_out = !out_valid_q || pop;
    occ      = 2'(out_valid_q) + 2'(skid_valid) + 2'(inflight);
    issue    = en && !rd_ptr[ADDR_W] && ((occ - 2'(pop)) < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      acc_cnt     <= '0;
    end else if (!en) begin
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      acc_cnt     <= '0;
    end else begin
      inflight <= issue;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (pop) acc_cnt <= acc_cnt + 1'b1;
      if (load_out) begin
        if (skid_valid) begin
          // skid holds the older word; the returning read refills skid
          out_valid_q <= 1'b1;
          out_data_q  <= skid_data;
          skid_valid  <= inflight;
          if (inflight) skid_data <= rd_data;
        end else begin
          out_valid_q <= inflight;
          if (inflight) out_data_q <= rd_data;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= rd_data;
      end
    end
  end

  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_valid_q && (acc_cnt == LAST_ADDR);

endmodule

// File: rtl/systemizer_ctrl.sv
// rtl/systemizer_ctrl.sv - job controller: load matrix, run systemizer with retries, unload result
// Ports: clk, rst_n; cmd_start; host_* load stream; out_* unload stream;
// busy/done/fail/success/try_cnt status; sys_* systemizer handshake and
// RAM requests; mem_* single-port RAM with 1-cycle read latency.
import systemizer_pkg::*;

module systemizer_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int MAX_TRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              success,
  output logic [2:0]        try_cnt,
  output logic              sys_start,
  input  logic              sys_done,
  input  logic              sys_success,
  input  logic              sys_fail,
  input  logic              sys_rd_en,
  input  logic [ADDR_W-1:0] sys_rd_addr,
  input  logic              sys_wr_en,
  input  logic [ADDR_W-1:0] sys_wr_addr,
  input  logic [DATA_W-1:0] sys_wr_data,
  output logic [DATA_W-1:0] sys_rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [2:0]        TRY_LIMIT = 3'(MAX_TRY);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        try_q, try_d;
  logic              fail_q, fail_d;
  logic              success_q, success_d;

  logic              unload_en;
  logic [ADDR_W-1:0] ub_addr;
  logic              ub_valid;
  logic [DATA_W-1:0] ub_data;
  logic              ub_last;

  // RAM reads have no side effects, so the read address is routed whether
  // or not the systemizer flags it with sys_rd_en.
  logic unused_sys_rd_en;
  assign unused_sys_rd_en = sys_rd_en;

  assign unload_en = (state_q == ST_UNLOAD);

  sysctl_unload_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_unload_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (unload_en),
    .rd_addr   (ub_addr),
    .rd_data   (mem_rdata),
    .out_valid (ub_valid),
    .out_data  (ub_data),
    .out_ready (out_ready),
    .out_last  (ub_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      try_q     <= '0;
      fail_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      try_q     <= try_d;
      fail_q    <= fail_d;
      success_q <= success_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    try_d       = try_q;
    fail_d      = fail_q;
    success_d   = success_q;
    host_ready  = 1'b0;
    sys_start   = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sys_rd_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d   = ST_LOAD;
          addr_d    = '0;
          try_d     = '0;
          fail_d    = 1'b0;
          success_d = 1'b0;
        end
      end

      ST_LOAD: begin
        host_ready = 1'b1;
        mem_we     = host_valid;
        mem_addr   = addr_q;
        mem_wdata  = host_data;
        if (host_valid) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = ST_START;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      ST_START: begin
        sys_start = 1'b1;
        if (try_q != TRY_CNT_MAX) try_d = try_q + 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        mem_we      = sys_wr_en;
        mem_addr    = sys_wr_en ? sys_wr_addr : sys_rd_addr;
        mem_wdata   = sys_wr_data;
        sys_rd_data = mem_rdata;
        if (sys_done) begin
          addr_d = '0;
          if (sys_status(sys_success, sys_fail) == SYS_ST_SUCCESS) begin
            state_d = ST_UNLOAD;
          end else if (try_q < TRY_LIMIT) begin
            state_d = ST_LOAD;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_UNLOAD: begin
        mem_addr = ub_addr;
        if (ub_valid && out_ready && ub_last) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid = unload_en && ub_valid;
  assign out_data  = (unload_en && ub_valid) ? ub_data : '0;
  assign fail      = fail_q;
  assign success   = success_q;
  assign try_cnt   = try_q;

endmodule

// File: tb/tb_systemizer_ctrl.sv
// tb/tb_systemizer_ctrl.sv - directed self-checking bench for systemizer_ctrl
module tb_systemizer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_start, host_valid, host_ready, out_valid, out_ready;
  logic [7:0] host_data, out_data;
  logic       busy, done, fail, success, sys_start;
  logic [2:0] try_cnt;
  logic       sys_done, sys_success, sys_fail;
  logic       sys_rd_en, sys_wr_en;
  logic [3:0] sys_rd_addr, sys_wr_addr;
  logic [7:0] sys_wr_data, sys_rd_data;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  systemizer_ctrl #(.DATA_W(8), .ADDR_W(4), .MAX_TRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .fail(fail), .success(success), .try_cnt(try_cnt),
    .sys_start(sys_start), .sys_done(sys_done), .sys_success(sys_success), .sys_fail(sys_fail),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_wr_en(sys_wr_en),
    .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data), .sys_rd_data(sys_rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // single-port RAM, registered read
  logic [7:0] ram [16];
  int         wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  // event monitors
  int   start_cnt = 0, done_cnt = 0, ov_cnt = 0, hr_rise = 0;
  logic hr_prev = 1'b0;
  always @(negedge clk) begin
    if (sys_start) start_cnt <= start_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (host_ready && !hr_prev) hr_rise <= hr_rise + 1;
    hr_prev <= host_ready;
  end

  int         total = 0, passed = 0;
  logic [7:0] exp_words [16];
  logic [7:0] got [16];
  int         stall_total = 0;
  int         s0, d0, r0, v0, wsnap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int c = 0;
      host_valid = 1'b1;
      host_data  = base + 8'(i);
      while (!host_ready && c < 100) begin
        tick();
        c++;
      end
      if (c >= 100) check("load_ready_timeout", 32'(host_ready), 1);
      tick();
    end
    host_valid = 1'b0;
  endtask

  task automatic sys_run(input int lat, input logic succ, input logic fl, input logic rw);
    int c = 0;
    while (!sys_start && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) check("sys_start_timeout", 32'(sys_start), 1);
    tick();
    if (rw) begin
      sys_wr_en = 1'b1; sys_wr_addr = 4'd3; sys_wr_data = 8'hA5;
      tick();
      sys_wr_en = 1'b0;
      sys_rd_en = 1'b1; sys_rd_addr = 4'd5;
      tick();
      check("run_rd_addr5", 32'(sys_rd_data), 32'h45);
      sys_rd_addr = 4'd3;
      tick();
      check("run_rd_addr3", 32'(sys_rd_data), 32'hA5);
      sys_rd_en = 1'b0;
    end
    repeat (lat) tick();
    sys_done = 1'b1; sys_success = succ; sys_fail = fl;
    tick();
    sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
  endtask

  task automatic unload(input logic [3:0] pat);
    int         n = 0, k = 0, first = -1, stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    while (n < 16 && k < 200) begin
      out_ready = pat[k % 4];
      if (out_valid && first < 0) first = k;
      if (prev_stall) begin
        stall_total++;
        if (!out_valid || out_data !== prev_d) stall_err++;
      end
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      tick();
      k++;
    end
    out_ready = 1'b0;
    check("unload_word_count", 32'(n), 16);
    check("first_valid_latency_le2", 32'(first >= 0 && first <= 2), 1);
    check("stall_data_stable", 32'(stall_err), 0);
    for (int i = 0; i < 16; i++) check($sformatf("word%0d", i), 32'(got[i]), 32'(exp_words[i]));
    check("done_after_last_word", 32'(done), 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; host_valid = 1'b0; host_data = 8'h3C; out_ready = 1'b0;
    sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
    sys_rd_en = 1'b0; sys_rd_addr = 4'd0; sys_wr_en = 1'b0; sys_wr_addr = 4'd0; sys_wr_data = 8'h00;
    repeat (3) tick();
    check("reset_ctrl_outs", {24'd0, host_ready, out_valid, busy, done, fail, success, sys_start, mem_we}, 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_mem_wdata", 32'(mem_wdata), 0);
    check("reset_sys_rd_data", 32'(sys_rd_data), 0);
    check("reset_try_cnt", 32'(try_cnt), 0);
    host_data = 8'h00;
    rst_n = 1'b1;
    tick();

    // one clean job
    s0 = start_cnt; d0 = done_cnt;
    do_cmd();
    check("t1_host_ready", 32'(host_ready), 1);
    load(8'h00, 16);
    sys_run(20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'(i);
    unload(4'b1111);
    tick();
    check("t1_sys_start_pulses", 32'(start_cnt - s0), 1);
    check("t1_done_pulses", 32'(done_cnt - d0), 1);
    check("t1_success", 32'(success), 1);
    check("t1_fail", 32'(fail), 0);
    check("t1_try_cnt", 32'(try_cnt), 1);
    check("t1_idle_busy", 32'(busy), 0);

    // fail, fail, success
    s0 = start_cnt; r0 = hr_rise;
    do_cmd();
    load(8'h10, 16); sys_run(4, 1'b0, 1'b1, 1'b0);
    load(8'h20, 16); sys_run(4, 1'b0, 1'b1, 1'b0);
    load(8'h30, 16); sys_run(4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'h30 + 8'(i);
    unload(4'b1111);
    tick();
    check("t2_host_ready_rises", 32'(hr_rise - r0), 3);
    check("t2_sys_start_pulses", 32'(start_cnt - s0), 3);
    check("t2_success", 32'(success), 1);
    check("t2_try_cnt", 32'(try_cnt), 3);

    // three failures
    v0 = ov_cnt; d0 = done_cnt;
    do_cmd();
    for (int t = 0; t < 3; t++) begin
      load(8'h50, 16);
      sys_run(3, 1'b0, 1'b1, 1'b0);
    end
    check("t3_done_now", 32'(done), 1);
    tick();
    check("t3_fail", 32'(fail), 1);
    check("t3_success", 32'(success), 0);
    check("t3_try_cnt", 32'(try_cnt), 3);
    check("t3_done_pulses", 32'(done_cnt - d0), 1);
    check("t3_no_out_valid", 32'(ov_cnt - v0), 0);
    check("t3_idle_busy", 32'(busy), 0);

    // systemizer write during RUN, stalled unload; stray sys writes outside RUN
    do_cmd();
    sys_wr_en = 1'b1; sys_wr_addr = 4'd9; sys_wr_data = 8'hEE; sys_rd_en = 1'b1;
    load(8'h40, 16);
    check("t4_start_sys_rd_data_zero", 32'(sys_rd_data), 0);
    check("t4_start_no_mem_we", 32'(mem_we), 0);
    sys_wr_en = 1'b0; sys_rd_en = 1'b0;
    stall_total = 0;
    sys_run(5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'h40 + 8'(i);
    exp_words[3] = 8'hA5;
    unload(4'b1001);
    tick();
    check("t4_stalls_seen", 32'(stall_total > 0), 1);
    check("t4_success", 32'(success), 1);

    // reset mid-load, then a full job
    do_cmd();
    load(8'h50, 7);
    host_valid = 1'b1; host_data = 8'h57;
    rst_n = 1'b0;
    #1;
    check("t5_reset_ctrl_outs", {26'd0, host_ready, busy, mem_we, success, fail, done}, 0);
    check("t5_reset_mem_addr", 32'(mem_addr), 0);
    check("t5_reset_mem_wdata", 32'(mem_wdata), 0);
    check("t5_reset_try_cnt", 32'(try_cnt), 0);
    wsnap = wr_cnt;
    tick(); tick();
    check("t5_no_write_in_reset", 32'(wr_cnt - wsnap), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("t5_waits_for_cmd", {30'd0, busy, host_ready}, 0);
    check("t5_no_write_after_release", 32'(wr_cnt - wsnap), 0);
    host_valid = 1'b0;
    s0 = start_cnt; d0 = done_cnt;
    do_cmd();
    load(8'h60, 16);
    sys_run(6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'h60 + 8'(i);
    unload(4'b1111);
    tick();
    check("t5_try_cnt", 32'(try_cnt), 1);
    check("t5_success", 32'(success), 1);
    check("t5_sys_start_pulses", 32'(start_cnt - s0), 1);
    check("t5_done_pulses", 32'(done_cnt - d0), 1);

    // sys_done in IDLE, cmd_start in RUN, both flags set
    sys_done = 1'b1; sys_fail = 1'b1; sys_wr_en = 1'b1;
    #1;
    check("t6_idle_no_mem_we", 32'(mem_we), 0);
    tick();
    sys_done = 1'b0; sys_fail = 1'b0; sys_wr_en = 1'b0;
    check("t6_idle_sys_done_ignored", {28'd0, busy, done, fail, success}, 32'h1);
    do_cmd();
    load(8'h70, 16);
    check("t6_sys_start", 32'(sys_start), 1);
    tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("t6_cmd_in_run_ignored", {27'd0, busy, host_ready, sys_start, try_cnt[1:0]}, 32'h11);
    sys_done = 1'b1; sys_success = 1'b1; sys_fail = 1'b1;
    tick();
    sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
    check("t6_both_flags_reload", 32'(host_ready), 1);
    check("t6_both_flags_no_valid", 32'(out_valid), 0);
    load(8'h80, 16);
    sys_run(2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_words[i] = 8'h80 + 8'(i);
    unload(4'b1111);
    tick();
    check("t6_try_cnt", 32'(try_cnt), 2);
    check("t6_success_fail", {30'd0, success, fail}, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
